// File: rtl/saber_cmd_sequencer.sv
// saber_cmd_sequencer: replays a stored SABER instruction stream from a program ROM into the compute core command port
// Ports: clk, rst (async, active-high); start (one-cycle run pulse);
//   prog_addr / prog_data: synchronous ROM port, data valid the cycle after the address;
//   core_done: compute-core completion pulse; command_in / command_we0 / command_we1: registered core command;
//   busy (FETCH/ISSUE/WAIT), program_done (clean halt), error (sticky timeout or pc overflow).
module saber_cmd_sequencer #(
  parameter int PROG_AW = 10,
  parameter int unsigned START_ADDR = 0,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PROG_AW-1:0] prog_addr,
  input  logic [36:0]        prog_data,
  input  logic               core_done,
  output logic [34:0]        command_in,
  output logic               command_we0,
  output logic               command_we1,
  output logic               busy,
  output logic               program_done,
  output logic               error
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, HALT} state_t;
  localparam logic [PROG_AW-1:0] START = PROG_AW'(START_ADDR);
  state_t state, state_n;
  logic [PROG_AW-1:0] pc, pc_n;
  logic [23:0] cnt, cnt_n;
  logic [34:0] cmd_n;
  logic we0_n, we1_n, done_n, err_n, step;
  assign prog_addr = pc;
  assign busy = state inside {FETCH, ISSUE, WAIT};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= START;
      cnt <= '0;
      command_in <= '0;
      command_we0 <= 1'b0;
      command_we1 <= 1'b0;
      program_done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      cnt <= cnt_n;
      command_in <= cmd_n;
      command_we0 <= we0_n;
      command_we1 <= we1_n;
      program_done <= done_n;
      error <= err_n;
    end
  always_comb begin
    state_n = state;
    pc_n = pc;
    cnt_n = cnt;
    cmd_n = command_in;
    we0_n = 1'b0;
    we1_n = 1'b0;
    done_n = program_done;
    err_n = error;
    step = 1'b0;
    case (state)
      IDLE, HALT: if (start) begin
        state_n = FETCH;
        pc_n = START;
        done_n = 1'b0;
        err_n = 1'b0;
      end
      FETCH: state_n = ISSUE;
      ISSUE: if (prog_data == 37'd31) begin
        state_n = HALT;
        done_n = 1'b1;
      end else begin
        cmd_n = prog_data[34:0];
        we1_n = prog_data[36];
        we0_n = prog_data[35];
        if (prog_data[35] && prog_data[4:0] != 5'd0) begin
          state_n = WAIT;
          cnt_n = '0;
        end else
          step = 1'b1;
      end
      WAIT: if (core_done)
        step = 1'b1;
      else if (TIMEOUT != 24'd0 && cnt == TIMEOUT - 24'd1) begin
        state_n = HALT;
        err_n = 1'b1;
      end else
        cnt_n = cnt + 24'd1;
      default: state_n = IDLE;
    endcase
    // advancing past the last ROM address is an error, never a wrap
    if (step) begin
      state_n = &pc ? HALT : FETCH;
      err_n = error | (&pc);
      pc_n = &pc ? pc : pc + 1'b1;
    end
  end
endmodule

// File: tb/tb_saber_cmd_sequencer.sv
// tb_saber_cmd_sequencer: self-checking bench for saber_cmd_sequencer (word table plus multi-cycle corner sequences)
module tb_saber_cmd_sequencer;
  localparam logic [36:0] HALT_W = 37'd31;
  typedef struct {
    logic [36:0] word;
    int lat;
    logic waits;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, core_done_a = 1'b0, core_done_b = 1'b0;
  logic [3:0] addr_a;
  logic [2:0] addr_b;
  logic [36:0] data_a, data_b;
  logic [34:0] cmd_a, cmd_b;
  logic we0_a, we1_a, busy_a, done_a, err_a;
  logic we0_b, we1_b, busy_b, done_b, err_b;
  logic [36:0] rom_a [16];
  logic [36:0] rom_b [8];
  logic [36:0] exp_q [$];
  vec_t vecs [5];
  int checks = 0, errors = 0;

  saber_cmd_sequencer #(.PROG_AW(4), .TIMEOUT(24'd16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .prog_addr(addr_a), .prog_data(data_a),
    .core_done(core_done_a), .command_in(cmd_a), .command_we0(we0_a), .command_we1(we1_a),
    .busy(busy_a), .program_done(done_a), .error(err_a)
  );
  saber_cmd_sequencer #(.PROG_AW(3), .TIMEOUT(24'd0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .prog_addr(addr_b), .prog_data(data_b),
    .core_done(core_done_b), .command_in(cmd_b), .command_we0(we0_b), .command_we1(we1_b),
    .busy(busy_b), .program_done(done_b), .error(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    data_a <= rom_a[addr_a];
    data_b <= rom_b[addr_b];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // advance one cycle; strobes seen on dut_a are matched against the expected-word queue
  task automatic tick();
    logic [36:0] e;
    @(negedge clk);
    if (we0_a || we1_a) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_strobe actual=%0h required=none", {we1_a, we0_a, cmd_a});
      end else begin
        e = exp_q.pop_front();
        chk("sb_word", 64'({we1_a, we0_a, cmd_a}), 64'(e));
      end
    end
    if (we0_b || we1_b) begin
      checks++;
      errors++;
      $display("FAIL b_unexpected_strobe actual=%0h required=0", {we1_b, we0_b});
    end
  endtask

  task automatic load_a(input logic [36:0] w0, input logic [36:0] w1, input logic [36:0] w2);
    for (int i = 0; i < 16; i++) rom_a[i] = HALT_W;
    rom_a[0] = w0;
    rom_a[1] = w1;
    rom_a[2] = w2;
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    load_a(v.word, HALT_W, HALT_W);
    if (v.word[36] || v.word[35]) exp_q.push_back(v.word);
    pulse_a();
    tick();
    tick();
    chk("issue_cmd", 64'(cmd_a), 64'(v.word[34:0]));
    if (v.waits) begin
      chk("wait_busy", 64'(busy_a), 64'd1);
      repeat (v.lat) tick();
      chk("wait_hold_cmd", 64'(cmd_a), 64'(v.word[34:0]));
      chk("wait_pc_held", 64'(addr_a), 64'd0);
      core_done_a = 1'b1;
      tick();
      core_done_a = 1'b0;
    end
    tick();
    chk("pre_halt_done", 64'(done_a), 64'd0);
    tick();
    chk("halt_done", 64'(done_a), 64'd1);
    chk("halt_busy", 64'(busy_a), 64'd0);
    chk("halt_err", 64'(err_a), 64'd0);
    chk("halt_pc", 64'(addr_a), 64'd1);
  endtask

  initial begin
    vecs[0] = '{37'h1000200020, 0, 1'b0};
    vecs[1] = '{37'h08F8000F81, 10, 1'b1};
    vecs[2] = '{37'h0800000000, 0, 1'b0};
    vecs[3] = '{37'h00F8000F81, 0, 1'b0};
    vecs[4] = '{37'h1800000003, 0, 1'b1};
    load_a(HALT_W, HALT_W, HALT_W);
    for (int i = 0; i < 8; i++) rom_b[i] = {2'b00, 35'(256 + i)};
    tick();
    tick();
    chk("rst_cmd", 64'(cmd_a), 64'd0);
    chk("rst_strobes", 64'({we1_a, we0_a}), 64'd0);
    chk("rst_status", 64'({busy_a, done_a, err_a}), 64'd0);
    chk("rst_pc", 64'(addr_a), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 64'(busy_a), 64'd0);
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    // clear word then hold word: no waits, hold word changes command_in silently
    load_a(37'h0800000000, 37'h00F8000F81, HALT_W);
    exp_q.push_back(37'h0800000000);
    pulse_a();
    tick();
    tick();
    chk("clr_cmd", 64'(cmd_a), 64'd0);
    tick();
    tick();
    chk("hold_cmd", 64'(cmd_a), 64'h0F8000F81);
    chk("hold_strobes", 64'({we1_a, we0_a}), 64'd0);
    tick();
    tick();
    chk("clr_hold_done", 64'(done_a), 64'd1);
    // timeout after exactly 16 WAIT cycles
    load_a(37'h08F8000F81, HALT_W, HALT_W);
    exp_q.push_back(37'h08F8000F81);
    pulse_a();
    tick();
    tick();
    repeat (15) tick();
    chk("to_err_early", 64'(err_a), 64'd0);
    chk("to_busy_early", 64'(busy_a), 64'd1);
    tick();
    chk("to_err", 64'(err_a), 64'd1);
    chk("to_done", 64'(done_a), 64'd0);
    chk("to_busy", 64'(busy_a), 64'd0);
    exp_q.push_back(37'h08F8000F81);
    pulse_a();
    chk("to_err_cleared", 64'(err_a), 64'd0);
    tick();
    tick();
    core_done_a = 1'b1;
    tick();
    core_done_a = 1'b0;
    tick();
    tick();
    chk("to_rerun_done", 64'(done_a), 64'd1);
    // asynchronous reset in the middle of WAIT
    exp_q.push_back(37'h08F8000F81);
    pulse_a();
    tick();
    tick();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("arst_cmd", 64'(cmd_a), 64'd0);
    chk("arst_status", 64'({busy_a, done_a, err_a, we1_a, we0_a}), 64'd0);
    chk("arst_pc", 64'(addr_a), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run_vec(vecs[1]);
    // pc overflow on a 3-bit ROM of hold words
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (15) tick();
    chk("ovf_err_early", 64'(err_b), 64'd0);
    chk("ovf_pc_last", 64'(addr_b), 64'd7);
    tick();
    chk("ovf_err", 64'(err_b), 64'd1);
    chk("ovf_done", 64'(done_b), 64'd0);
    chk("ovf_busy", 64'(busy_b), 64'd0);
    chk("ovf_cmd", 64'(cmd_b), 64'(rom_b[7][34:0]));
    chk("ovf_no_wrap", 64'(addr_b), 64'd7);
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/saber_cmd_sequencer.md
Name: saber_cmd_sequencer

Overview:
- Program-ROM reader that replays a stored SABER instruction stream into the compute core's command port.
- Each 37-bit ROM word is {command_we1, command_we0, command_in[34:0]}. These are the same words the command-generation benches print.
- Fetches words in order and issues each as a one-cycle write strobe. After any compute command it waits for the core's done pulse, and it stops on the halt word.
- Sits between the instruction ROM and the compute core. It replaces bench-driven command sequencing in the KEM top level.

Parameters:
- PROG_AW, 10, instruction ROM address width (max 1024 words).
- START_ADDR, 0, program counter value loaded on start.
- TIMEOUT, 24'hFFFFFF, maximum WAIT cycles before error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution at START_ADDR. Accepted only in IDLE or HALT.
- prog_addr  out  PROG_AW  ROM address; combinational from the pc register.
- prog_data  in  37  ROM read data; synchronous ROM, valid the cycle after the address is presented.
- core_done  in  1  compute-core completion pulse.
- command_in  out  35  command word to the core; registered.
- command_we0  out  1  command/opcode write strobe; registered, one-cycle pulse.
- command_we1  out  1  length-register write strobe; registered, one-cycle pulse.
- busy  out  1  high in FETCH, ISSUE and WAIT.
- program_done  out  1  high in HALT after a clean halt.
- error  out  1  sticky until start or reset; set on timeout or pc overflow.

Behaviour:
- Reset (async) takes effect immediately, including mid-program:
  - state=IDLE, pc=START_ADDR, timeout counter=0.
  - command_in=0, command_we0=0, command_we1=0.
  - busy=0, program_done=0, error=0.
- Word fields:
  - we1 = bit 36, we0 = bit 35.
  - For a we1 word: command_in = {3'b0, out_len[31:16], in_len[15:0]}.
  - For a we0 word: command_in = {dest[34:25], src2[24:15], src1[14:5], opcode[4:0]}.
- States: IDLE, FETCH, ISSUE, WAIT, HALT.
- IDLE / HALT:
  - start → pc=START_ADDR, program_done=0, error=0, go to FETCH.
  - All other inputs are ignored.
- FETCH: prog_addr=pc; the ROM latches at this edge; go to ISSUE.
- ISSUE decodes prog_data:
  - Halt word (we1=0, we0=0, command_in=35'd31): go to HALT with program_done=1. Do not drive the word out.
  - Any other word: at the edge, command_in<=bits[34:0], command_we1<=bit36, command_we0<=bit35.
  - If we0=1 and opcode!=0: go to WAIT and clear the timeout counter.
  - Otherwise: pc<=pc+1, go to FETCH.
  - Words with both strobes low (hold words) are still driven onto command_in. They update the core's command bus without a strobe.
  - we0 words with opcode 0 (clear/setup words) do not wait.
- Strobe timing:
  - command_we0/we1 are high for exactly the one cycle after the ISSUE edge, then forced to 0.
  - command_in holds its value until the next ISSUE.
- WAIT:
  - core_done is sampled every cycle, including the first WAIT cycle.
  - core_done=1 → pc<=pc+1, go to FETCH.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT without done → error=1, go to HALT with program_done=0.
  - core_done outside WAIT is ignored.
- Throughput: 2 cycles per non-waiting word. A waiting word takes 2 cycles plus the done latency.
- pc overflow: if pc=2^PROG_AW-1 would increment without a halt → error=1, go to HALT; pc does not wrap.
- start while busy is ignored. Simultaneous start and rst: rst wins.
- command_we0 and command_we1 both set in one word are issued as given; the sequencer does not check for this.

Test Plan:
- Length word 37'h1000200020 at addr 0, then halt word 37'h000000001F, start pulse → one cycle of command_we1=1 with command_in=35'h000200020, then program_done=1, busy=0, error=0, 4 cycles after start.
- Word 37'h8F8000F81 ({124,0,124,op 1}, we0) with core_done raised 10 cycles after the strobe → command_we0 pulses once, the next fetch starts only after done, and command_in stays 35'h0F8000F81 throughout WAIT.
- Clear word 37'h800000000 (we0, op 0) followed by 37'h0F8000F81 (hold) → neither word waits; command_in updates on the second word with no strobe.
- TIMEOUT=16 and core_done never asserted → error=1 and program_done=0 exactly 16 cycles into WAIT; a subsequent start clears error.
- Assert rst during WAIT → all outputs zero immediately; start re-runs the program from START_ADDR.
- PROG_AW=3 with the ROM filled with non-halt hold words → error=1 after addr 7 is issued, with no wrap to addr 0.
